// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - MEM pipeline stage: EX/MEM register, data-memory handshake, store forwarding, MEM/WB register
//
// Ports:
//   clk, rst            : single clock, synchronous active-high reset
//   ex_*                : instruction fields from EX, captured into the M register
//   forward_busB        : from the MEM forwarding detector; store data comes from wb_data
//   m_Rt, m_MemWr       : M-stage store source register / store flag, to the detector
//   mem_stall           : hold IF..EX and the ex_* inputs stable this cycle
//   dm_req/we/addr/be/wdata, dm_ready, dm_rdata : data-memory request/ready handshake
//   wb_valid, wb_Rw, wb_RegWr, wb_data          : MEM/WB register outputs
//   misalign_err        : one-cycle pulse when a misaligned access is dropped
module mem_access_stage #(
    parameter int DW = 32,
    parameter int AW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ex_valid,
    input  logic [AW-1:0] ex_alu_result,
    input  logic [DW-1:0] ex_busB,
    input  logic [4:0]    ex_Rt,
    input  logic [4:0]    ex_Rw,
    input  logic          ex_RegWr,
    input  logic          ex_MemWr,
    input  logic          ex_MemRd,
    input  logic [1:0]    ex_size,
    input  logic          ex_sign,
    input  logic          forward_busB,
    output logic [4:0]    m_Rt,
    output logic          m_MemWr,
    output logic          mem_stall,
    output logic          dm_req,
    output logic          dm_we,
    output logic [AW-1:0] dm_addr,
    output logic [3:0]    dm_be,
    output logic [DW-1:0] dm_wdata,
    input  logic          dm_ready,
    input  logic [DW-1:0] dm_rdata,
    output logic          wb_valid,
    output logic [4:0]    wb_Rw,
    output logic          wb_RegWr,
    output logic [DW-1:0] wb_data,
    output logic          misalign_err
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    // M (EX/MEM) register
    logic          r_m_valid;
    logic [AW-1:0] r_m_alu;
    logic [DW-1:0] r_m_busB;
    logic [4:0]    r_m_Rt;
    logic [4:0]    r_m_Rw;
    logic          r_m_RegWr;
    logic          r_m_MemWr;
    logic          r_m_MemRd;
    logic [1:0]    r_m_size;
    logic          r_m_sign;

    // Request captured on the first cycle so WAIT never re-forwards
    logic [AW-1:0] r_h_addr;
    logic [3:0]    r_h_be;
    logic          r_h_we;
    logic [DW-1:0] r_h_wdata;

    // WB (MEM/WB) register
    logic          r_wb_valid;
    logic [4:0]    r_wb_Rw;
    logic          r_wb_RegWr;
    logic [DW-1:0] r_wb_data;

    logic          w_is_mem;
    logic          w_is_load;
    logic          w_aligned;
    logic          w_mem_op;
    logic          w_misaligned;
    logic          w_stall;
    logic [DW-1:0] w_store_data;
    logic [AW-1:0] w_new_addr;
    logic [3:0]    w_new_be;
    logic [DW-1:0] w_new_wdata;
    logic [7:0]    w_byte;
    logic [15:0]   w_half;
    logic [DW-1:0] w_load_data;

    assign w_is_mem  = r_m_valid & (r_m_MemWr | r_m_MemRd);
    // A store flag wins if both are set, so only pure loads take the read path
    assign w_is_load = r_m_MemRd & ~r_m_MemWr;

    always_comb begin
        w_aligned = 1'b1;
        case (r_m_size)
            2'b00:   w_aligned = 1'b1;
            2'b01:   w_aligned = ~r_m_alu[0];
            default: w_aligned = (r_m_alu[1:0] == 2'b00);
        endcase
    end

    assign w_mem_op     = w_is_mem & w_aligned;
    assign w_misaligned = w_is_mem & ~w_aligned;
    assign w_stall      = w_mem_op & ~dm_ready;

    assign w_store_data = forward_busB ? r_wb_data : r_m_busB;
    assign w_new_addr   = {r_m_alu[AW-1:2], 2'b00};

    // Byte-lane enables and lane-replicated store data
    always_comb begin
        w_new_be    = 4'b1111;
        w_new_wdata = w_store_data;
        case (r_m_size)
            2'b00: begin
                w_new_be    = 4'b0001 << r_m_alu[1:0];
                w_new_wdata = {4{w_store_data[7:0]}};
            end
            2'b01: begin
                w_new_be    = r_m_alu[1] ? 4'b1100 : 4'b0011;
                w_new_wdata = {2{w_store_data[15:0]}};
            end
            default: begin
                w_new_be    = 4'b1111;
                w_new_wdata = w_store_data;
            end
        endcase
    end

    // Load lane extraction and extension
    always_comb begin
        w_byte = dm_rdata[7:0];
        case (r_m_alu[1:0])
            2'b00:   w_byte = dm_rdata[7:0];
            2'b01:   w_byte = dm_rdata[15:8];
            2'b10:   w_byte = dm_rdata[23:16];
            default: w_byte = dm_rdata[31:24];
        endcase
        w_half = r_m_alu[1] ? dm_rdata[31:16] : dm_rdata[15:0];
        case (r_m_size)
            2'b00:   w_load_data = {{24{r_m_sign & w_byte[7]}}, w_byte};
            2'b01:   w_load_data = {{16{r_m_sign & w_half[15]}}, w_half};
            default: w_load_data = dm_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        dm_req      = 1'b0;
        dm_we       = 1'b0;
        dm_addr     = '0;
        dm_be       = 4'b0000;
        dm_wdata    = '0;
        case (r_state)
            S_IDLE: begin
                if (w_mem_op) begin
                    dm_req   = 1'b1;
                    dm_we    = r_m_MemWr;
                    dm_addr  = w_new_addr;
                    dm_be    = w_new_be;
                    dm_wdata = w_new_wdata;
                    if (!dm_ready) begin
                        w_state_nxt = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                dm_req   = 1'b1;
                dm_we    = r_h_we;
                dm_addr  = r_h_addr;
                dm_be    = r_h_be;
                dm_wdata = r_h_wdata;
                if (dm_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_h_addr  <= '0;
            r_h_be    <= 4'b0000;
            r_h_we    <= 1'b0;
            r_h_wdata <= '0;
        end else if (r_state == S_IDLE && w_mem_op) begin
            r_h_addr  <= w_new_addr;
            r_h_be    <= w_new_be;
            r_h_we    <= r_m_MemWr;
            r_h_wdata <= w_new_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_m_valid <= 1'b0;
            r_m_alu   <= '0;
            r_m_busB  <= '0;
            r_m_Rt    <= 5'd0;
            r_m_Rw    <= 5'd0;
            r_m_RegWr <= 1'b0;
            r_m_MemWr <= 1'b0;
            r_m_MemRd <= 1'b0;
            r_m_size  <= 2'b00;
            r_m_sign  <= 1'b0;
        end else if (!w_stall) begin
            r_m_valid <= ex_valid;
            r_m_alu   <= ex_alu_result;
            r_m_busB  <= ex_busB;
            r_m_Rt    <= ex_Rt;
            r_m_Rw    <= ex_Rw;
            r_m_RegWr <= ex_RegWr;
            r_m_MemWr <= ex_MemWr;
            r_m_MemRd <= ex_MemRd;
            r_m_size  <= ex_size;
            r_m_sign  <= ex_sign;
        end
    end

    // Stall cycles and dropped misaligned accesses become WB bubbles
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wb_valid <= 1'b0;
            r_wb_Rw    <= 5'd0;
            r_wb_RegWr <= 1'b0;
            r_wb_data  <= '0;
        end else begin
            r_wb_valid <= r_m_valid & ~w_stall & ~w_misaligned;
            r_wb_RegWr <= r_m_RegWr & r_m_valid & ~w_stall & ~w_misaligned;
            r_wb_Rw    <= r_m_Rw;
            r_wb_data  <= w_is_load ? w_load_data : DW'(r_m_alu);
        end
    end

    assign mem_stall    = w_stall;
    assign misalign_err = w_misaligned;
    assign m_Rt         = r_m_Rt;
    assign m_MemWr      = r_m_valid & r_m_MemWr;
    assign wb_valid     = r_wb_valid;
    assign wb_Rw        = r_wb_Rw;
    assign wb_RegWr     = r_wb_RegWr;
    assign wb_data      = r_wb_data;

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - scoreboard bench for mem_access_stage with random traffic and a memory model
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic [31:0] ex_alu_result;
    logic [31:0] ex_busB;
    logic [4:0]  ex_Rt;
    logic [4:0]  ex_Rw;
    logic        ex_RegWr;
    logic        ex_MemWr;
    logic        ex_MemRd;
    logic [1:0]  ex_size;
    logic        ex_sign;
    logic        forward_busB;
    logic [4:0]  m_Rt;
    logic        m_MemWr;
    logic        mem_stall;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [3:0]  dm_be;
    logic [31:0] dm_wdata;
    logic        dm_ready = 1'b0;
    logic [31:0] dm_rdata = '0;
    logic        wb_valid;
    logic [4:0]  wb_Rw;
    logic        wb_RegWr;
    logic [31:0] wb_data;
    logic        misalign_err;

    mem_access_stage dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_alu_result(ex_alu_result), .ex_busB(ex_busB),
        .ex_Rt(ex_Rt), .ex_Rw(ex_Rw), .ex_RegWr(ex_RegWr), .ex_MemWr(ex_MemWr),
        .ex_MemRd(ex_MemRd), .ex_size(ex_size), .ex_sign(ex_sign),
        .forward_busB(forward_busB), .m_Rt(m_Rt), .m_MemWr(m_MemWr),
        .mem_stall(mem_stall), .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
        .dm_be(dm_be), .dm_wdata(dm_wdata), .dm_ready(dm_ready), .dm_rdata(dm_rdata),
        .wb_valid(wb_valid), .wb_Rw(wb_Rw), .wb_RegWr(wb_RegWr), .wb_data(wb_data),
        .misalign_err(misalign_err)
    );

    always #5 clk = ~clk;

    // Forwarding detector: store in M, writer of the same non-zero register in WB
    assign forward_busB = m_MemWr & wb_RegWr & (wb_Rw == m_Rt) & (m_Rt != 5'd0);

    typedef struct {
        logic        valid;
        int          kind;      // 0 alu, 1 load, 2 store
        logic [31:0] addr;
        logic [31:0] busB;
        logic [4:0]  rt;
        logic [4:0]  rw;
        logic        regwr;
        logic [1:0]  size;
        logic        sign;
        int          lat;
    } instr_t;

    typedef struct {
        logic [4:0]  rw;
        logic        regwr;
        logic [31:0] data;
    } wb_exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
    } dm_exp_t;

    wb_exp_t     wb_q[$];
    dm_exp_t     dm_q[$];
    int          lat_q[$];
    logic [31:0] shadow[16];
    logic [31:0] tbmem[16];

    int          n_checks = 0;
    int          n_fail   = 0;
    int          exp_mis  = 0;
    int          obs_mis  = 0;

    logic        prev_ok  = 1'b0;
    logic [4:0]  prev_rw  = '0;
    logic [31:0] prev_val = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: applied in program order when an instruction enters M
    task automatic model(input instr_t in);
        int          sz;
        int          off;
        int          idx;
        logic [31:0] word;
        logic [31:0] res;
        logic [31:0] d;
        dm_exp_t     de;
        wb_exp_t     we;
        if (!in.valid) begin
            prev_ok = 1'b0;
            return;
        end
        sz  = (in.size == 2'd3) ? 2 : int'(in.size);
        off = int'(in.addr % 4);
        idx = int'((in.addr / 4) % 16);
        res = in.addr;
        if (in.kind != 0) begin
            if ((sz == 1 && off % 2 != 0) || (sz == 2 && off != 0)) begin
                exp_mis++;
                prev_ok = 1'b0;
                return;
            end
            lat_q.push_back(in.lat);
            de.addr = in.addr - off;
            if (sz == 0)      de.be = 4'(1 << off);
            else if (sz == 1) de.be = 4'(3 << off);
            else              de.be = 4'hF;
            if (in.kind == 1) begin
                word = shadow[idx];
                if (sz == 0) begin
                    res = (word >> (off * 8)) & 32'hFF;
                    if (in.sign && res >= 32'h80) res = res + 32'hFFFF_FF00;
                end else if (sz == 1) begin
                    res = (word >> (off * 8)) & 32'hFFFF;
                    if (in.sign && res >= 32'h8000) res = res + 32'hFFFF_0000;
                end else begin
                    res = word;
                end
                de.we    = 1'b0;
                de.wdata = '0;
            end else begin
                d = (prev_ok && prev_rw == in.rt && in.rt != 0) ? prev_val : in.busB;
                if (sz == 0)      de.wdata = (d & 32'hFF) * 32'h0101_0101;
                else if (sz == 1) de.wdata = (d & 32'hFFFF) * 32'h0001_0001;
                else              de.wdata = d;
                de.we = 1'b1;
                for (int l = 0; l < 4; l++)
                    if (de.be[l]) shadow[idx][8*l +: 8] = de.wdata[8*l +: 8];
            end
            dm_q.push_back(de);
        end
        we.rw    = in.rw;
        we.regwr = in.regwr;
        we.data  = res;
        wb_q.push_back(we);
        prev_ok  = in.regwr;
        prev_rw  = in.rw;
        prev_val = res;
    endtask

    task automatic drive(input instr_t in);
        ex_valid      = in.valid;
        ex_alu_result = in.addr;
        ex_busB       = in.busB;
        ex_Rt         = in.rt;
        ex_Rw         = in.rw;
        ex_RegWr      = in.regwr;
        ex_MemWr      = (in.kind == 2);
        ex_MemRd      = (in.kind == 1);
        ex_size       = in.size;
        ex_sign       = in.sign;
    endtask

    // Called at posedge+1; returns at posedge+1 after the slot is taken into M
    task automatic issue(input instr_t in);
        logic stall;
        int   guard;
        drive(in);
        guard = 0;
        do begin
            @(negedge clk);
            stall = mem_stall;
            @(posedge clk);
            #1;
            guard++;
            if (guard > 100) begin
                $display("FAIL issue_timeout actual=stalled required=accepted");
                $fatal(1, "issue timeout");
            end
        end while (stall);
        model(in);
    endtask

    function automatic instr_t mk(input int kind, input logic [31:0] addr, input logic [31:0] busB,
                                  input logic [4:0] rt, input logic [4:0] rw, input logic regwr,
                                  input logic [1:0] size, input logic sign, input int lat);
        instr_t t;
        t.valid = 1'b1; t.kind = kind; t.addr = addr; t.busB = busB; t.rt = rt; t.rw = rw;
        t.regwr = regwr; t.size = size; t.sign = sign; t.lat = lat;
        return t;
    endfunction

    function automatic instr_t rnd();
        instr_t t;
        t.valid = ($urandom_range(0, 9) != 0);
        t.kind  = $urandom_range(0, 2);
        t.addr  = (t.kind == 0) ? $urandom : 32'h100 + $urandom_range(0, 63);
        t.busB  = $urandom;
        t.rt    = 5'($urandom_range(0, 3));
        t.rw    = 5'($urandom_range(0, 3));
        t.regwr = ($urandom_range(0, 3) != 0);
        t.size  = 2'($urandom_range(0, 3));
        t.sign  = 1'($urandom_range(0, 1));
        t.lat   = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 4);
        return t;
    endfunction

    // Data memory: variable latency, zero latency answers in the request cycle
    int wait_left = 0;
    bit busy      = 0;
    always @(posedge clk) begin
        #2;
        if (dm_req) begin
            if (!busy) begin
                busy      = 1;
                wait_left = (lat_q.size() > 0) ? lat_q.pop_front() : 0;
            end
            if (wait_left == 0) begin
                dm_ready = 1'b1;
                dm_rdata = tbmem[dm_addr[5:2]];
                if (dm_we)
                    for (int l = 0; l < 4; l++)
                        if (dm_be[l]) tbmem[dm_addr[5:2]][8*l +: 8] = dm_wdata[8*l +: 8];
                busy = 0;
            end else begin
                dm_ready = 1'b0;
                dm_rdata = $urandom;
                wait_left--;
            end
        end else begin
            dm_ready = 1'b0;
            busy     = 0;
        end
    end

    // Monitor: pops expectations whenever the DUT presents a result
    logic        pend = 1'b0;
    logic [31:0] h_addr, h_wdata;
    logic [3:0]  h_be;
    logic        h_we;
    always @(negedge clk) begin
        if (rst) begin
            pend = 1'b0;
        end else begin
            if (wb_valid) begin
                if (wb_q.size() == 0) begin
                    chk("wb_unexpected", 32'd1, 32'd0);
                end else begin
                    wb_exp_t e;
                    e = wb_q.pop_front();
                    chk("wb_Rw", 32'(wb_Rw), 32'(e.rw));
                    chk("wb_RegWr", 32'(wb_RegWr), 32'(e.regwr));
                    chk("wb_data", wb_data, e.data);
                end
            end
            if (misalign_err) begin
                obs_mis++;
                chk("misalign_dm_req", 32'(dm_req), 32'd0);
                chk("misalign_stall", 32'(mem_stall), 32'd0);
            end
            if (dm_req) begin
                if (pend) begin
                    chk("hold_addr", dm_addr, h_addr);
                    chk("hold_be", 32'(dm_be), 32'(h_be));
                    chk("hold_we", 32'(dm_we), 32'(h_we));
                    chk("hold_wdata", dm_wdata, h_wdata);
                end
                chk("stall_vs_ready", 32'(mem_stall), 32'(!dm_ready));
                if (dm_ready) begin
                    pend = 1'b0;
                    if (dm_q.size() == 0) begin
                        chk("dm_unexpected", 32'd1, 32'd0);
                    end else begin
                        dm_exp_t e;
                        e = dm_q.pop_front();
                        chk("dm_addr", dm_addr, e.addr);
                        chk("dm_be", 32'(dm_be), 32'(e.be));
                        chk("dm_we", 32'(dm_we), 32'(e.we));
                        if (e.we) chk("dm_wdata", dm_wdata, e.wdata);
                    end
                end else begin
                    pend    = 1'b1;
                    h_addr  = dm_addr;
                    h_be    = dm_be;
                    h_we    = dm_we;
                    h_wdata = dm_wdata;
                end
            end else begin
                pend = 1'b0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    instr_t bub;
    initial begin
        bub = mk(0, '0, '0, '0, '0, 1'b0, 2'b00, 1'b0, 0);
        bub.valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            shadow[i] = $urandom;
            tbmem[i]  = shadow[i];
        end
        shadow[0] = 32'h0080_0000;
        tbmem[0]  = 32'h0080_0000;

        rst = 1'b1;
        drive(bub);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_m_Rt", 32'(m_Rt), 32'd0);
        chk("rst_m_MemWr", 32'(m_MemWr), 32'd0);
        chk("rst_stall", 32'(mem_stall), 32'd0);
        chk("rst_dm_req", 32'(dm_req), 32'd0);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_wb_RegWr", 32'(wb_RegWr), 32'd0);
        chk("rst_wb_Rw", 32'(wb_Rw), 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_misalign", 32'(misalign_err), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Directed sequence
        issue(mk(0, 32'h1234, 32'h0, 5'd0, 5'd5, 1'b1, 2'b10, 1'b0, 0));
        issue(mk(2, 32'h103, 32'hAB, 5'd7, 5'd0, 1'b0, 2'b00, 1'b0, 0));
        issue(mk(1, 32'h102, 32'h0, 5'd0, 5'd4, 1'b1, 2'b00, 1'b1, 2));
        issue(mk(0, 32'hDEAD, 32'h0, 5'd0, 5'd3, 1'b1, 2'b10, 1'b0, 0));
        issue(mk(2, 32'h104, 32'h5555, 5'd3, 5'd0, 1'b0, 2'b10, 1'b0, 3));
        issue(mk(1, 32'h102, 32'h0, 5'd0, 5'd2, 1'b1, 2'b10, 1'b0, 0));
        issue(mk(0, 32'h77, 32'h0, 5'd0, 5'd1, 1'b1, 2'b10, 1'b0, 0));
        repeat (4) issue(bub);

        // Reset while the memory is still waiting
        prev_ok = 1'b0;
        lat_q.push_back(20);
        drive(mk(1, 32'h108, 32'h0, 5'd0, 5'd1, 1'b1, 2'b10, 1'b0, 20));
        @(posedge clk);
        #1;
        drive(bub);
        @(negedge clk);
        chk("wait_dm_req", 32'(dm_req), 32'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("wait_stall", 32'(mem_stall), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        lat_q.delete();
        @(negedge clk);
        chk("rstwait_dm_req", 32'(dm_req), 32'd0);
        chk("rstwait_stall", 32'(mem_stall), 32'd0);
        chk("rstwait_wb_valid", 32'(wb_valid), 32'd0);
        @(posedge clk);
        #1;
        prev_ok = 1'b0;

        // Random traffic
        for (int i = 0; i < 400; i++) issue(rnd());
        repeat (6) issue(bub);

        chk("wb_queue_drained", 32'(wb_q.size()), 32'd0);
        chk("dm_queue_drained", 32'(dm_q.size()), 32'd0);
        chk("misalign_count", 32'(obs_mis), 32'(exp_mis));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
